// File: rtl/seq_alu_pkg.sv
// seq_alu_pkg -- shared definitions for the execute-stage ALU.
//   DATA_WID        : default operand/result width
//   ALU_*           : 3-bit opcode encodings (ADD, SUB, AND, OR, XOR, MUL)
//   CC_*            : bit positions inside the 4-bit condition-code register
//   alu_state_e     : control FSM states
package seq_alu_pkg;

  localparam int DATA_WID = 32;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;
  localparam logic [2:0] ALU_MUL = 3'd5;

  localparam int CC_ZF = 3;
  localparam int CC_SF = 2;
  localparam int CC_OF = 1;
  localparam int CC_CF = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,  // no result held
    S_MUL  = 2'd1,  // multiplier iterating
    S_HOLD = 2'd2   // result held, out_valid asserted
  } alu_state_e;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter -- shift-add unsigned multiplier, one multiplier bit per cycle.
// Ports:
//   clk, rst        : clock, asynchronous active-high reset
//   start           : load operands and begin (ignored unless idle by caller)
//   a, b            : multiplicand / multiplier
//   busy            : iteration in progress
//   done            : final iteration happens at the coming edge; lo and
//                     hi_nonzero show the finished product during this cycle
//   lo              : low WIDTH bits of the product
//   hi_nonzero      : high WIDTH bits of the product are non-zero
module alu_mul_iter
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = DATA_WID
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic             hi_nonzero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 busy_q, busy_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  // {high accumulator, remaining multiplier bits / finished low bits}
  logic [2*WIDTH-1:0]   prod_q, prod_d, prod_step;
  logic [WIDTH:0]       hi_sum;
  logic                 last;

  always_comb begin
    // Add the multiplicand into the high half when the current multiplier
    // bit (prod_q[0]) is set, then shift the whole product right by one.
    hi_sum    = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
              + (prod_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    prod_step = {hi_sum, prod_q[WIDTH-1:1]};
    last      = busy_q && (cnt_q == CW'(WIDTH-1));

    busy_d  = busy_q;
    cnt_d   = cnt_q;
    mcand_d = mcand_q;
    prod_d  = prod_q;
    if (start) begin
      busy_d  = 1'b1;
      cnt_d   = '0;
      mcand_d = a;
      prod_d  = {{WIDTH{1'b0}}, b};
    end else if (busy_q) begin
      prod_d = prod_step;
      cnt_d  = cnt_q + CW'(1);
      if (last) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else begin
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      mcand_q <= mcand_d;
      prod_q  <= prod_d;
    end
  end

  assign busy       = busy_q;
  assign done       = last;
  assign lo         = prod_step[WIDTH-1:0];
  assign hi_nonzero = |prod_step[2*WIDTH-1:WIDTH];

endmodule

// File: rtl/seq_alu.sv
// seq_alu -- handshaked execute-stage ALU: valE = ALUB op ALUA.
// Optional feature macro: SEQ_ALU_MUL_EN (iterative unsigned MUL, opcode 5).
// Without it opcode 5 is reported as illegal and no multiplier is built.
// Ports:
//   CLK, RST              : clock, asynchronous active-high reset
//   in_valid / in_ready   : operation handshake (accept on valid && ready)
//   ALUfun                : 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL, 6-7 illegal
//   ALUA, ALUB            : operands (SUB computes B - A)
//   set_cond              : write CC when this operation's result is loaded
//   out_valid / out_ready : result handshake
//   valE                  : registered result
//   out_err               : illegal-opcode flag, qualified by out_valid
//   CC                    : {ZF, SF, OF, CF}
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = DATA_WID
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ALUfun,
  input  logic [WIDTH-1:0] ALUA,
  input  logic [WIDTH-1:0] ALUB,
  input  logic             set_cond,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] valE,
  output logic             out_err,
  output logic [3:0]       CC
);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] val_q, val_d;
  logic             err_q, err_d;
  logic [3:0]       cc_q, cc_d;

  logic             accept;
  logic [WIDTH:0]   sum_w, diff_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_cf, alu_of;
  logic             op_illegal, op_is_mul;
  logic [3:0]       cc_alu;

  // ---------------- single-cycle datapath ----------------
  always_comb begin
    sum_w      = {1'b0, ALUB} + {1'b0, ALUA};
    diff_w     = {1'b0, ALUB} - {1'b0, ALUA};  // MSB set means borrow
    alu_res    = '0;
    alu_cf     = 1'b0;
    alu_of     = 1'b0;
    op_illegal = 1'b0;
    op_is_mul  = 1'b0;
    case (ALUfun)
      ALU_ADD: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_cf  = sum_w[WIDTH];
        alu_of  = (ALUA[WIDTH-1] == ALUB[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != ALUA[WIDTH-1]);
      end
      ALU_SUB: begin
        alu_res = diff_w[WIDTH-1:0];
        alu_cf  = diff_w[WIDTH];
        alu_of  = (ALUA[WIDTH-1] != ALUB[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != ALUB[WIDTH-1]);
      end
      ALU_AND: alu_res = ALUB & ALUA;
      ALU_OR:  alu_res = ALUB | ALUA;
      ALU_XOR: alu_res = ALUB ^ ALUA;
`ifdef SEQ_ALU_MUL_EN
      ALU_MUL: op_is_mul = 1'b1;
`endif
      default: op_illegal = 1'b1;  // result stays 0
    endcase

    cc_alu        = 4'b0000;
    cc_alu[CC_ZF] = (alu_res == '0);
    cc_alu[CC_SF] = alu_res[WIDTH-1];
    cc_alu[CC_OF] = alu_of;
    cc_alu[CC_CF] = alu_cf;
  end

  // Ready depends only on state and out_ready so a HOLD result can drain and
  // a new op enter on the same edge.
  assign in_ready = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
  assign accept   = in_valid && in_ready;

`ifdef SEQ_ALU_MUL_EN
  // ---------------- iterative multiplier ----------------
  logic             mul_start, mul_busy, mul_done, mul_hi_nz;
  logic [WIDTH-1:0] mul_lo;
  logic             mul_setcc_q;
  logic [3:0]       cc_mul;

  assign mul_start = accept && op_is_mul;

  alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk        (CLK),
    .rst        (RST),
    .start      (mul_start),
    .a          (ALUA),
    .b          (ALUB),
    .busy       (mul_busy),
    .done       (mul_done),
    .lo         (mul_lo),
    .hi_nonzero (mul_hi_nz)
  );

  always_comb begin
    cc_mul        = 4'b0000;
    cc_mul[CC_ZF] = (mul_lo == '0);
    cc_mul[CC_SF] = mul_lo[WIDTH-1];
    cc_mul[CC_OF] = mul_hi_nz;
    cc_mul[CC_CF] = mul_hi_nz;
  end

  // set_cond must be remembered across the iterations.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)            mul_setcc_q <= 1'b0;
    else if (mul_start) mul_setcc_q <= set_cond;
  end
`endif

  // ---------------- control FSM ----------------
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    err_d   = err_q;
    cc_d    = cc_q;
    case (state_q)
      S_IDLE, S_HOLD: begin
        if ((state_q == S_HOLD) && out_ready) state_d = S_IDLE;
        if (accept) begin
          if (op_is_mul) begin
            state_d = S_MUL;
          end else begin
            state_d = S_HOLD;
            val_d   = alu_res;
            err_d   = op_illegal;
            if (set_cond && !op_illegal) cc_d = cc_alu;
          end
        end
      end
      S_MUL: begin
`ifdef SEQ_ALU_MUL_EN
        if (mul_done) begin
          state_d = S_HOLD;
          val_d   = mul_lo;
          err_d   = 1'b0;
          if (mul_setcc_q) cc_d = cc_mul;
        end else if (!mul_busy) begin
          // multiplier lost its job; never strand the pipeline
          state_d = S_IDLE;
        end
`else
        state_d = S_IDLE;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      val_q   <= '0;
      err_q   <= 1'b0;
      cc_q    <= 4'b0000;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      err_q   <= err_d;
      cc_q    <= cc_d;
    end
  end

  assign out_valid = (state_q == S_HOLD);
  assign valE      = val_q;
  assign out_err   = err_q;
  assign CC        = cc_q;

endmodule

// File: tb/tb_seq_alu.sv
// tb_seq_alu -- directed self-checking bench for seq_alu (WIDTH = 32).
// Inputs change 1 ns after the rising edge; outputs are sampled there too.
module tb_seq_alu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  alufun;
  logic [31:0] alua;
  logic [31:0] alub;
  logic        set_cond;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] vale;
  logic        out_err;
  logic [3:0]  cc;

  int tests;
  int fails;

  seq_alu #(.WIDTH(32)) dut (
    .CLK       (clk),
    .RST       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .ALUfun    (alufun),
    .ALUA      (alua),
    .ALUB      (alub),
    .set_cond  (set_cond),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .valE      (vale),
    .out_err   (out_err),
    .CC        (cc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Offer one operation, wait for the accepting edge, then drop in_valid.
  task automatic issue(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic sc);
    in_valid = 1'b1;
    alufun   = op;
    alua     = a;
    alub     = b;
    set_cond = sc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    $display("[TB] op=%0d A=%h B=%h sc=%0b -> valE=%h err=%0b CC=%b ov=%0b",
             op, a, b, sc, vale, out_err, cc, out_valid);
  endtask

  initial begin
    int n;
    tests = 0;
    fails = 0;
    rst = 1'b1; in_valid = 1'b0; alufun = 3'd0; alua = '0; alub = '0;
    set_cond = 1'b0; out_ready = 1'b1;

    // ---- reset state ----
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_valE", vale, 32'd0);
    chk("rst_err", 32'(out_err), 32'd0);
    chk("rst_cc", 32'(cc), 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);

    // ---- ADD overflow into sign bit ----
    issue(3'd0, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1);
    chk("add_ov_valid", 32'(out_valid), 32'd1);
    chk("add_ov_valE", vale, 32'h8000_0000);
    chk("add_ov_cc", 32'(cc), 32'b0110);

    // ---- SUB with borrow, then AND without CC write (back-to-back) ----
    issue(3'd1, 32'd5, 32'd3, 1'b1);
    chk("sub_valE", vale, 32'hFFFF_FFFE);
    chk("sub_cc", 32'(cc), 32'b0101);
    issue(3'd2, 32'd0, 32'h0000_00FF, 1'b0);
    chk("and_valE", vale, 32'd0);
    chk("and_cc_held", 32'(cc), 32'b0101);

    // ---- ADD carry out with zero result ----
    issue(3'd0, 32'hFFFF_FFFF, 32'd1, 1'b1);
    chk("add_cf_valE", vale, 32'd0);
    chk("add_cf_cc", 32'(cc), 32'b1001);

    // ---- XOR / OR ----
    issue(3'd4, 32'hF0F0_F0F0, 32'hFFFF_0000, 1'b1);
    chk("xor_valE", vale, 32'h0F0F_F0F0);
    chk("xor_cc", 32'(cc), 32'b0000);
    issue(3'd3, 32'h8000_0000, 32'd1, 1'b1);
    chk("or_valE", vale, 32'h8000_0001);
    chk("or_cc", 32'(cc), 32'b0100);

    // ---- SUB signed overflow, no borrow ----
    issue(3'd1, 32'd1, 32'h8000_0000, 1'b1);
    chk("sub_ov_valE", vale, 32'h7FFF_FFFF);
    chk("sub_ov_cc", 32'(cc), 32'b0010);

    // ---- illegal opcode 7: valE 0, err, CC unchanged ----
    issue(3'd7, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    chk("ill7_valid", 32'(out_valid), 32'd1);
    chk("ill7_err", 32'(out_err), 32'd1);
    chk("ill7_valE", vale, 32'd0);
    chk("ill7_cc", 32'(cc), 32'b0010);
    issue(3'd2, 32'h0000_00FF, 32'h0000_000F, 1'b0);
    chk("after_ill_err", 32'(out_err), 32'd0);
    chk("after_ill_valE", vale, 32'h0000_000F);

    // ---- eight back-to-back ADDs, one result per cycle ----
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1; alufun = 3'd0; set_cond = 1'b1;
      alua = 32'(i); alub = 32'h7FFF_FFFC;
      @(posedge clk);
      #1;
      $display("[TB] b2b add %0d -> valE=%h CC=%b ov=%0b", i, vale, cc, out_valid);
      chk("b2b_valid", 32'(out_valid), 32'd1);
      chk("b2b_valE", vale, 32'h7FFF_FFFC + 32'(i));
      chk("b2b_cc", 32'(cc), (i >= 4) ? 32'b0110 : 32'b0000);
    end

    // ---- stall 3 cycles with a new op pending ----
    alufun = 3'd1; alua = 32'd1; alub = 32'd3; set_cond = 1'b1;
    out_ready = 1'b0;
    #1;
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      $display("[TB] stall %0d -> valE=%h CC=%b rdy=%0b", i, vale, cc, in_ready);
      chk("stall_valE", vale, 32'h8000_0003);
      chk("stall_cc", 32'(cc), 32'b0110);
      chk("stall_valid", 32'(out_valid), 32'd1);
      chk("stall_rdy", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("unstall_valE", vale, 32'd2);
    chk("unstall_cc", 32'(cc), 32'b0000);
    @(posedge clk);
    #1;
    chk("drained_valid", 32'(out_valid), 32'd0);

    // ---- asynchronous reset mid-cycle while holding a result ----
    out_ready = 1'b0;
    issue(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b1);
    chk("pre_rst_valE", vale, 32'd1);
    chk("pre_rst_cc", 32'(cc), 32'b0001);
    #3 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_valE", vale, 32'd0);
    chk("arst_cc", 32'(cc), 32'd0);
    #1 rst = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);

    // ---- MUL ----
    issue(3'd0, 32'hFFFF_FFFF, 32'd2, 1'b1);  // CC := 0001
`ifdef SEQ_ALU_MUL_EN
    issue(3'd5, 32'h0001_0000, 32'h0001_0000, 1'b1);
    chk("mul_busy_valid", 32'(out_valid), 32'd0);
    chk("mul_busy_rdy", 32'(in_ready), 32'd0);
    n = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        n = k;
        break;
      end
    end
    $display("[TB] mul 0x10000*0x10000 -> latency=%0d valE=%h CC=%b", n, vale, cc);
    chk("mul_latency", 32'(n), 32'd32);
    chk("mul_valE", vale, 32'd0);
    chk("mul_cc", 32'(cc), 32'b1011);
    chk("mul_err", 32'(out_err), 32'd0);

    issue(3'd5, 32'd2, 32'hFFFF_FFFF, 1'b1);
    for (int k = 1; k <= 40 && !out_valid; k++) begin
      @(posedge clk);
      #1;
    end
    chk("mul2_valE", vale, 32'hFFFF_FFFE);
    chk("mul2_cc", 32'(cc), 32'b0111);

    // reset during iteration 10: nothing may come out
    issue(3'd5, 32'd3, 32'd5, 1'b1);
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #2 rst = 1'b0;
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) n++;
    end
    $display("[TB] mul aborted by reset -> out_valid cycles=%0d", n);
    chk("mul_abort_valid", 32'(n), 32'd0);
    chk("mul_abort_rdy", 32'(in_ready), 32'd1);
`else
    issue(3'd5, 32'h0001_0000, 32'h0001_0000, 1'b1);
    chk("mul_off_valid", 32'(out_valid), 32'd1);
    chk("mul_off_err", 32'(out_err), 32'd1);
    chk("mul_off_valE", vale, 32'd0);
    chk("mul_off_cc", 32'(cc), 32'b0001);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised, handshaked successor to the execute-stage ALU. Computes `valE = ALUB op ALUA` for add, sub, and, or, xor and an optional iterative unsigned multiply. Holds a registered condition-code register updated together with the result. Sits in the execute stage between decode (operand source) and memory/write-back (result sink); valid/ready on both sides allows multi-cycle operations and downstream stalls.

## Interface
Parameters:
- `WIDTH`, default 32 (`DATA_WID`): operand/result width, ≥ 2.

Ports:
- `CLK`  in  1: single clock, rising edge.
- `RST`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: operation offered.
- `in_ready`  out  1: operation accepted when `in_valid && in_ready` at a rising edge.
- `ALUfun`  in  3: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL, 6–7 illegal.
- `ALUA`  in  WIDTH: operand A.
- `ALUB`  in  WIDTH: operand B; SUB is B−A, so "greater" means B > A.
- `set_cond`  in  1: update CC when this operation's result is produced.
- `out_valid`  out  1: `valE`/`out_err` valid.
- `out_ready`  in  1: consumer takes the result when `out_valid && out_ready`.
- `valE`  out  WIDTH: registered result.
- `out_err`  out  1: illegal opcode flag, qualified by `out_valid`.
- `CC`  out  4: {ZF, SF, OF, CF} at bits 3..0.

## Operation
- FSM states:
  - IDLE: no result held.
  - MUL: iterating.
  - HOLD: result held, `out_valid`=1.
- Transitions:
  - IDLE, accept of a non-MUL op → HOLD.
  - IDLE, accept of MUL → MUL.
  - MUL, iteration counter reaches WIDTH → HOLD.
  - HOLD, `out_ready` with no new accept → IDLE.
  - HOLD, `out_ready` with accept → HOLD (non-MUL) or MUL (MUL).
- `in_ready` = IDLE || (HOLD && `out_ready`). It is combinational from `out_ready` only, never from `in_valid`.
- Operands, `ALUfun` and `set_cond` are captured at accept; input changes afterwards have no effect.
- Arithmetic is modulo 2^WIDTH.
  - ADD: CF = carry out; OF = A and B same sign, result sign differs.
  - SUB: CF = borrow (B < A unsigned); OF = signs of B and A differ, result sign ≠ sign of B.
  - AND/OR/XOR: CF=OF=0.
  - MUL: unsigned; `valE` = low WIDTH bits of the 2·WIDTH product; CF=OF=1 iff the high half ≠ 0.
- ZF = (`valE`==0), SF = `valE`[WIDTH-1], for all legal ops.
- CC is written on the same edge `valE` is loaded, only if the captured `set_cond`=1 and the opcode is legal; otherwise CC holds.
- Illegal opcode: `valE`=0, `out_err`=1, CC unchanged, single-cycle.
- `RST` asserted at any time, including mid-MUL: state → IDLE, iteration aborted, no partial result delivered.
- Reset values: `in_ready`=1 (after reset), `out_valid`=0, `valE`=0, `out_err`=0, CC=4'b0000.

## Timing
- Non-MUL op accepted at edge t: `out_valid`=1 and `valE`/CC updated after edge t (visible cycle t+1).
- MUL accepted at edge t: result after edge t+WIDTH (one product bit per cycle, WIDTH iterations, load on the last).
- Throughput: one non-MUL op per cycle while `out_ready`=1; back-to-back accept and drain in the same cycle is mandatory.
- Stall: `valE`, `out_err` and CC are stable while `out_valid && !out_ready`.
- `in_ready`=0 throughout MUL.

## Configuration
- `SEQ_ALU_MUL_EN` defined: MUL implemented as above.
- Undefined: opcode 5 treated as illegal (`valE`=0, `out_err`=1, single-cycle); no multiplier logic or iteration counter is synthesised.

## Structure
- Shared header `head.v` holds:
  - `DATA_WID`
  - opcode constants `_Add`, `_Sub`, `_And`, `_Or`, `_Xor`, `_Mul` (3-bit)
  - CC bit indices `ZF`=3, `SF`=2, `OF`=1, `CF`=0
- One sub-module, `alu_mul_iter`: shift-add unsigned multiplier.
  - Inputs: start, a, b.
  - Outputs: busy, done, lo, hi_nonzero.
  - Instantiated only under `SEQ_ALU_MUL_EN`.
- The FSM, flag logic and single-cycle datapath stay in `seq_alu`.

## Test plan
- Reset: assert `RST` asynchronously mid-cycle → `out_valid`=0, `valE`=0, CC=0 immediately; `in_ready`=1 after release.
- WIDTH=32, ADD A=1, B=0x7FFFFFFF, `set_cond`=1 → `valE`=0x80000000, CC=4'b0110 (SF, OF) one cycle after accept.
- SUB A=5, B=3, `set_cond`=1, then AND A=0, B=0xFF with `set_cond`=0 → first `valE`=0xFFFFFFFE, CC=4'b0101; second `valE`=0, CC still 4'b0101.
- Eight back-to-back ADDs with `out_ready` held 1, then `out_ready`=0 for 3 cycles → one result per cycle; `valE` and CC frozen during the stall, `in_ready`=0.
- MUL A=0x10000, B=0x10000 (`SEQ_ALU_MUL_EN` defined) → `valE`=0, CF=OF=1, ZF=1, `out_valid` exactly 32 cycles after accept; same test with the macro undefined → `out_err`=1 after 1 cycle.
- MUL accepted, `RST` pulsed on iteration 10 → no `out_valid`. Opcode 7 → `out_err`=1, `valE`=0, CC unchanged.
